// File: rtl/hdlc_rx_deframer.sv
// rtl/hdlc_rx_deframer.sv - HDLC receive deframer: flag hunt, zero destuff, abort, CRC-16 FCS check
// Optional macro HDLC_RX_STATS_EN adds saturating good/crc/abort frame counters.
module hdlc_rx_deframer #(
    parameter int MIN_BYTES = 4,
    parameter int MAX_BYTES = 1536,
    parameter int CNT_W     = 11
) (
    input  logic        netclk,
    input  logic        reset,
    input  logic        rxdata,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        frame_end,
    output logic [4:0]  frame_status,
    input  logic        stat_clr,
    output logic [15:0] stat_good,
    output logic [15:0] stat_crc_err,
    output logic [15:0] stat_abort
);
    typedef enum logic [1:0] {HUNT, FLAG, FRAME} state_t;

    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_BYTES);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);
    localparam logic [15:0]      CRC_INIT = 16'hFFFF;
    localparam logic [15:0]      RESIDUE  = 16'h1D0F;

    state_t           state;
    logic [2:0]       ones;
    logic [7:0]       acc;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] count;
    logic [15:0]      crc;
    logic [7:0]       hold0;
    logic [7:0]       hold1;

    logic [2:0]       ones_next;
    logic             is_stuff;
    logic             is_flag;
    logic             is_abort;
    logic             data_bit;
    logic             commit;
    logic [7:0]       acc_next;
    logic [CNT_W-1:0] count_inc;
    logic [4:0]       close_status;

    function automatic logic [15:0] crc_fold(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    // A 1 after five 1s is never data: it is either the sixth 1 of a flag or an abort.
    always_comb begin
        ones_next = rxdata ? ((ones == 3'd7) ? 3'd7 : ones + 3'd1) : 3'd0;
        is_stuff  = !rxdata && (ones == 3'd5);
        is_flag   = !rxdata && (ones == 3'd6);
        is_abort  = rxdata && (ones == 3'd6);
        data_bit  = !(is_stuff || is_flag || (rxdata && (ones >= 3'd5)));
        acc_next  = {rxdata, acc[7:1]};
        commit    = data_bit && (bit_cnt == 3'd7);
        count_inc = count + 1'b1;

        close_status    = {1'b0, (count < MIN_C), (bit_cnt != 3'd6), 1'b0, 1'b0};
        if ((count >= MIN_C) && (bit_cnt == 3'd6)) begin
            close_status[0] = (crc != RESIDUE);
        end
    end

    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            state        <= HUNT;
            ones         <= 3'd0;
            acc          <= 8'd0;
            bit_cnt      <= 3'd0;
            count        <= '0;
            crc          <= CRC_INIT;
            hold0        <= 8'd0;
            hold1        <= 8'd0;
            rx_data      <= 8'd0;
            rx_valid     <= 1'b0;
            rx_sof       <= 1'b0;
            frame_end    <= 1'b0;
            frame_status <= 5'd0;
        end else begin
            ones         <= ones_next;
            rx_valid     <= 1'b0;
            rx_sof       <= 1'b0;
            frame_end    <= 1'b0;
            frame_status <= 5'd0;
            case (state)
                HUNT: begin
                    if (is_flag) begin
                        state   <= FLAG;
                        acc     <= 8'd0;
                        bit_cnt <= 3'd0;
                        count   <= '0;
                        crc     <= CRC_INIT;
                    end
                end
                FLAG, FRAME: begin
                    if (is_abort) begin
                        state <= HUNT;
                        if (count != '0) begin
                            frame_end    <= 1'b1;
                            frame_status <= 5'b00010;
                        end
                    end else if (is_flag) begin
                        // Closing flag doubles as the opening flag of the next frame.
                        state   <= FLAG;
                        acc     <= 8'd0;
                        bit_cnt <= 3'd0;
                        count   <= '0;
                        crc     <= CRC_INIT;
                        if (count != '0) begin
                            frame_end    <= 1'b1;
                            frame_status <= close_status;
                        end
                    end else if (data_bit) begin
                        state   <= FRAME;
                        acc     <= acc_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (commit) begin
                            if (count_inc > MAX_C) begin
                                state        <= HUNT;
                                frame_end    <= 1'b1;
                                frame_status <= 5'b10000;
                            end else begin
                                count <= count_inc;
                                crc   <= crc_fold(crc, acc_next);
                                hold0 <= acc_next;
                                hold1 <= hold0;
                                // The two newest octets stay held back so the FCS is never delivered.
                                if (count >= TWO_C) begin
                                    rx_valid <= 1'b1;
                                    rx_data  <= hold1;
                                    rx_sof   <= (count == TWO_C);
                                end
                            end
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

`ifdef HDLC_RX_STATS_EN
    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            stat_good    <= 16'd0;
            stat_crc_err <= 16'd0;
            stat_abort   <= 16'd0;
        end else if (stat_clr) begin
            stat_good    <= 16'd0;
            stat_crc_err <= 16'd0;
            stat_abort   <= 16'd0;
        end else if (frame_end) begin
            if ((frame_status == 5'd0) && (stat_good != 16'hFFFF)) begin
                stat_good <= stat_good + 16'd1;
            end
            if (frame_status[0] && (stat_crc_err != 16'hFFFF)) begin
                stat_crc_err <= stat_crc_err + 16'd1;
            end
            if (frame_status[1] && (stat_abort != 16'hFFFF)) begin
                stat_abort <= stat_abort + 16'd1;
            end
        end
    end
`else
    logic stat_clr_unused;
    assign stat_clr_unused = stat_clr;
    assign stat_good       = 16'd0;
    assign stat_crc_err    = 16'd0;
    assign stat_abort      = 16'd0;
`endif

endmodule
